mac_array_seq_ctrl: RTL and testbench

// - Top-level sequencer for l0_and_mac_array; for each kernel index kij it runs:
//   - weight fetch into L0
//   - start_kernel_load pulse and a fixed settle wait
//   - activation fetch into L0
//   - start_mac_compute pulse
//   - OFIFO drain into psum memory
// - Sits between the shared input SRAM, the L0/MAC/OFIFO datapath and the psum SRAM.

---
 rtl/mac_array_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mac_array_seq_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq_ctrl.sv
// mac_array_seq_ctrl
//   Top-level sequencer for the L0 / MAC array datapath. For each kernel
//   index kij it fetches row weights into L0, pulses start_kernel_load and
//   waits 3*col cycles, fetches num_nij activations into L0, pulses
//   start_mac_compute, then drains num_nij OFIFO rows into psum memory at
//   kij*num_nij + n.
//
// Ports
//   clk, reset (sync, active-low)
//   start, cfg_num_nij, cfg_num_kij      job request, config latched on start
//   l0_o_full                            L0 back-pressure, blocks SRAM reads
//   ofifo_valid                          OFIFO has a psum row
//   mem_rd_en, mem_rd_addr               input-SRAM read
//   l0_wr                                L0 write (mem_rd_en delayed 1 cycle)
//   start_kernel_load, start_mac_compute 1-cycle pulses
//   num_nij_to_compute                   latched cfg_num_nij
//   ofifo_rd                             OFIFO pop
//   psum_wr_en, psum_wr_addr             psum-SRAM write (ofifo_rd delayed 1)
//   kij_idx, busy, done                  status
//
// Build option
//   CTRL_PERF_CNT_EN : adds perf_cycles / perf_stalls saturating counters.
module mac_array_seq_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int NIJ_W    = 8,
  parameter int KIJ_W    = 4,
  parameter int ADDR_W   = 11,
  parameter int ACT_BASE = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NIJ_W-1:0]  cfg_num_nij,
  input  logic [KIJ_W-1:0]  cfg_num_kij,
  input  logic              l0_o_full,
  input  logic              ofifo_valid,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              l0_wr,
  output logic              start_kernel_load,
  output logic              start_mac_compute,
  output logic [NIJ_W-1:0]  num_nij_to_compute,
  output logic              ofifo_rd,
  output logic              psum_wr_en,
  output logic [ADDR_W-1:0] psum_wr_addr,
  output logic [KIJ_W-1:0]  kij_idx,
  output logic              busy,
  output logic              done
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0]  ROW_C     = CNT_W'(row);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(3 * col - 1);
  localparam logic [ADDR_W-1:0] ROW_A     = ADDR_W'(row);
  localparam logic [ADDR_W-1:0] ACT_A     = ADDR_W'(ACT_BASE);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FET, S_K_LOAD, S_K_WAIT, S_A_FET, S_COMP, S_DRAIN, S_NEXT, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [NIJ_W-1:0]   nij_q;
  logic [KIJ_W-1:0]   nkij_q;
  logic [KIJ_W-1:0]   kij_q;
  logic [CNT_W-1:0]   cnt_q;     // fetch index / settle counter
  logic [NIJ_W:0]     pop_q;     // OFIFO pops this kij
  logic [NIJ_W:0]     wr_q;      // psum writes this kij
  logic               l0_wr_q;
  logic               psum_wr_en_q;
  logic [CNT_W-1:0]   nij_c;

  assign nij_c = CNT_W'(nij_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = (cfg_num_nij == '0 || cfg_num_kij == '0) ? S_FIN : S_W_FET;
      // cnt_q reaching the limit means the last read went out last cycle,
      // so this cycle carries the final l0_wr.
      S_W_FET:  if (cnt_q == ROW_C) state_d = S_K_LOAD;
      S_K_LOAD: state_d = S_K_WAIT;
      S_K_WAIT: if (cnt_q == WAIT_LAST) state_d = S_A_FET;
      S_A_FET:  if (cnt_q == nij_c) state_d = S_COMP;
      S_COMP:   state_d = S_DRAIN;
      S_DRAIN:  if (psum_wr_en_q && (wr_q + (NIJ_W+1)'(1)) == {1'b0, nij_q}) state_d = S_NEXT;
      S_NEXT:   state_d = (kij_q == nkij_q - KIJ_W'(1)) ? S_FIN : S_W_FET;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd_en         = 1'b0;
    mem_rd_addr       = '0;
    ofifo_rd          = 1'b0;
    psum_wr_addr      = '0;
    start_kernel_load = (state_q == S_K_LOAD);
    start_mac_compute = (state_q == S_COMP);
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_FIN);
    unique case (state_q)
      S_W_FET: begin
        mem_rd_en   = !l0_o_full && (cnt_q < ROW_C);
        mem_rd_addr = ADDR_W'(kij_q) * ROW_A + ADDR_W'(cnt_q);
      end
      S_A_FET: begin
        mem_rd_en   = !l0_o_full && (cnt_q < nij_c);
        mem_rd_addr = ACT_A + ADDR_W'(cnt_q);
      end
      S_DRAIN: begin
        ofifo_rd     = ofifo_valid && (pop_q < {1'b0, nij_q});
        psum_wr_addr = ADDR_W'(kij_q) * ADDR_W'(nij_q) + ADDR_W'(wr_q);
      end
      default: ;
    endcase
  end

  assign l0_wr              = l0_wr_q;
  assign psum_wr_en         = psum_wr_en_q;
  assign num_nij_to_compute = nij_q;
  assign kij_idx            = kij_q;

  // Datapath counters and latched configuration
  always_ff @(posedge clk) begin
    if (!reset) begin
      nij_q        <= '0;
      nkij_q       <= '0;
      kij_q        <= '0;
      cnt_q        <= '0;
      pop_q        <= '0;
      wr_q         <= '0;
      l0_wr_q      <= 1'b0;
      psum_wr_en_q <= 1'b0;
    end else begin
      l0_wr_q      <= mem_rd_en;
      psum_wr_en_q <= ofifo_rd;
      if (state_q == S_IDLE && start) begin
        nij_q  <= cfg_num_nij;
        nkij_q <= cfg_num_kij;
        kij_q  <= '0;
      end
      if (state_q == S_NEXT && state_d == S_W_FET) kij_q <= kij_q + KIJ_W'(1);
      // cnt_q restarts from zero in every state it is used in.
      if (state_q != state_d)                       cnt_q <= '0;
      else if (mem_rd_en || state_q == S_K_WAIT)    cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == S_COMP) begin
        pop_q <= '0;
        wr_q  <= '0;
      end else begin
        if (ofifo_rd)     pop_q <= pop_q + (NIJ_W+1)'(1);
        if (psum_wr_en_q) wr_q  <= wr_q + (NIJ_W+1)'(1);
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;
  logic        stall;

  assign stall = ((state_q == S_W_FET || state_q == S_A_FET) && l0_o_full) ||
                 (state_q == S_DRAIN && !ofifo_valid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && perf_cycles_q != '1)  perf_cycles_q <= perf_cycles_q + 32'd1;
      if (stall && perf_stalls_q != '1) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
module tb_mac_array_seq_ctrl;
  localparam int ROW = 8, COL = 8, NIJ_W = 8, KIJ_W = 4, ADDR_W = 11, ACT_BASE = 64;
  localparam int AMOD = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset, start, l0_o_full, ofifo_valid;
  logic [NIJ_W-1:0]  cfg_num_nij;
  logic [KIJ_W-1:0]  cfg_num_kij;
  logic              mem_rd_en, l0_wr, start_kernel_load, start_mac_compute;
  logic [ADDR_W-1:0] mem_rd_addr, psum_wr_addr;
  logic [NIJ_W-1:0]  num_nij_to_compute;
  logic              ofifo_rd, psum_wr_en, busy, done;
  logic [KIJ_W-1:0]  kij_idx;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]       perf_cycles, perf_stalls;
`endif

  mac_array_seq_ctrl #(.row(ROW), .col(COL), .NIJ_W(NIJ_W), .KIJ_W(KIJ_W),
                       .ADDR_W(ADDR_W), .ACT_BASE(ACT_BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_nij(cfg_num_nij), .cfg_num_kij(cfg_num_kij),
    .l0_o_full(l0_o_full), .ofifo_valid(ofifo_valid),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .l0_wr(l0_wr),
    .start_kernel_load(start_kernel_load), .start_mac_compute(start_mac_compute),
    .num_nij_to_compute(num_nij_to_compute), .ofifo_rd(ofifo_rd),
    .psum_wr_en(psum_wr_en), .psum_wr_addr(psum_wr_addr), .kij_idx(kij_idx),
    .busy(busy), .done(done)
`ifdef CTRL_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_rd_en, mem_rd_addr, l0_wr, start_kernel_load, start_mac_compute,
                num_nij_to_compute, ofifo_rd, psum_wr_en, psum_wr_addr, kij_idx, busy, done});
  endfunction

  // Reference model: the full expected sequence of read addresses, psum
  // addresses and the kernel index active at each psum write.
  int exp_rd[$], exp_ps[$], exp_kij[$];
  int exp_nij;
  bit mon_en = 0, hold_chk = 0;

  task automatic build_model(input int nij, input int nkij);
    exp_rd.delete(); exp_ps.delete(); exp_kij.delete();
    exp_nij = nij;
    if (nij == 0 || nkij == 0) return;
    for (int k = 0; k < nkij; k++) begin
      for (int i = 0; i < ROW; i++) exp_rd.push_back((k * ROW + i) % AMOD);
      for (int n = 0; n < nij; n++) exp_rd.push_back((ACT_BASE + n) % AMOD);
      for (int n = 0; n < nij; n++) begin
        exp_ps.push_back((k * nij + n) % AMOD);
        exp_kij.push_back(k);
      end
    end
  endtask

  // Per-cycle compare process
  int cyc = 0, n_rd, n_l0wr, n_ps, n_done, n_busy;
  int last_ps_cyc, kl_cyc, start_cyc, last_rd_addr, last_ps_addr, last_ps_kij;
  bit kl_pend, rd_pend;
  logic prev_rd = 1'b0, prev_ofr = 1'b0;

  always @(negedge clk) begin
    int e;
    cyc++;
    if (mon_en) begin
      if (start && !busy) begin start_cyc = cyc; rd_pend = 1; end
      if (busy) n_busy++;
      check("l0_wr_delay", 64'(l0_wr), 64'(prev_rd));
      check("psum_wr_delay", 64'(psum_wr_en), 64'(prev_ofr));
      if (l0_wr) n_l0wr++;
      if (l0_o_full) begin
        check("rd_blocked", 64'(mem_rd_en), 64'd0);
        if (hold_chk && exp_rd.size() > 0) check("addr_hold", 64'(mem_rd_addr), 64'(exp_rd[0]));
      end
      if (mem_rd_en) begin
        n_rd++;
        last_rd_addr = mem_rd_addr;
        if (rd_pend) begin check("start_to_rd", 64'(cyc - start_cyc), 64'd1); rd_pend = 0; end
        if (kl_pend) begin check("kload_to_act_rd", 64'(cyc - kl_cyc), 64'(3 * COL + 1)); kl_pend = 0; end
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : -1;
        check("rd_addr", 64'(mem_rd_addr), 64'(e));
      end
      if (start_kernel_load) begin kl_cyc = cyc; kl_pend = 1; end
      if (ofifo_rd) check("ofifo_rd_valid", 64'(ofifo_valid), 64'd1);
      if (psum_wr_en) begin
        n_ps++;
        last_ps_cyc = cyc;
        last_ps_addr = psum_wr_addr;
        last_ps_kij = kij_idx;
        e = (exp_ps.size() > 0) ? exp_ps.pop_front() : -1;
        check("psum_addr", 64'(psum_wr_addr), 64'(e));
        e = (exp_kij.size() > 0) ? exp_kij.pop_front() : -1;
        check("psum_kij", 64'(kij_idx), 64'(e));
      end
      if (done) begin
        n_done++;
        rd_pend = 0;
        check("done_model_drained", 64'(exp_rd.size() + exp_ps.size()), 64'd0);
        if (exp_nij > 0) check("last_ps_to_done", 64'(cyc - last_ps_cyc), 64'd2);
        else             check("start_to_done", 64'(cyc - start_cyc), 64'd1);
      end
    end
    prev_rd  = mem_rd_en;
    prev_ofr = ofifo_rd;
  end

  task automatic clear_counts();
    n_rd = 0; n_l0wr = 0; n_ps = 0; n_done = 0; n_busy = 0;
    kl_pend = 0; rd_pend = 0; last_rd_addr = -1; last_ps_addr = -1; last_ps_kij = -1;
  endtask

  // One job: bp = 5-cycle l0_o_full hold after 10 activation reads,
  // gaps = ofifo_valid alternating each cycle, dup = second start while busy.
  task automatic run_job(input int nij, input int nkij, input bit bp, input bit gaps, input bit dup);
    int hold = 0;
    bit got = 0;
    build_model(nij, nkij);
    clear_counts();
    hold_chk = bp;
    @(posedge clk); #1;
    cfg_num_nij = NIJ_W'(nij); cfg_num_kij = KIJ_W'(nkij); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      if (n_done > 0) begin got = 1; break; end
      l0_o_full = 1'b0;
      if (bp && hold < 5 && n_rd >= ROW + 10) begin l0_o_full = 1'b1; hold++; end
      ofifo_valid = gaps ? ~ofifo_valid : 1'b1;
      if (dup && t == 20) begin start = 1'b1; cfg_num_nij = 8'd5; cfg_num_kij = 4'd7; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    check("job_finished", 64'(got), 64'd1);
    l0_o_full = 1'b0; ofifo_valid = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("single_done", 64'(n_done), 64'd1);
    check("idle_after_done", 64'(busy), 64'd0);
    hold_chk = 0;
  endtask

  initial begin
    bit got;
    reset = 1'b0; start = 1'b0; l0_o_full = 1'b0; ofifo_valid = 1'b1;
    cfg_num_nij = '0; cfg_num_kij = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1;

    // Basic run
    run_job(36, 1, 0, 0, 0);
    check("basic_rd_count", 64'(n_rd), 64'd44);
    check("basic_last_rd", 64'(last_rd_addr), 64'd99);
    check("basic_ps_count", 64'(n_ps), 64'd36);
    check("basic_last_ps", 64'(last_ps_addr), 64'd35);
    check("basic_num_nij", 64'(num_nij_to_compute), 64'd36);

    // Multi-kij
    run_job(4, 3, 0, 0, 0);
    check("multi_rd_count", 64'(n_rd), 64'd36);
    check("multi_ps_count", 64'(n_ps), 64'd12);
    check("multi_last_ps", 64'(last_ps_addr), 64'd11);
    check("multi_last_kij", 64'(last_ps_kij), 64'd2);

    // Back-pressure in the activation fetch
    run_job(36, 1, 1, 0, 0);
    check("bp_l0_wr_count", 64'(n_l0wr), 64'd44);
    check("bp_ps_count", 64'(n_ps), 64'd36);

    // OFIFO gaps during drain
    run_job(36, 1, 0, 1, 0);
    check("gap_ps_count", 64'(n_ps), 64'd36);
`ifdef CTRL_PERF_CNT_EN
    check("perf_stalls_min", 64'(perf_stalls >= 32'd35), 64'd1);
    check("perf_cycles", 64'(perf_cycles), 64'(n_busy));
`endif

    // Degenerate nij = 0
    run_job(0, 1, 0, 0, 0);
    check("zero_nij_reads", 64'(n_rd), 64'd0);
    check("zero_nij_ps", 64'(n_ps), 64'd0);

    // Start and cfg changes while busy are ignored
    run_job(4, 2, 0, 0, 1);
    check("dup_num_nij", 64'(num_nij_to_compute), 64'd4);
    check("dup_ps_count", 64'(n_ps), 64'd8);

    // Reset in the middle of DRAIN
    build_model(36, 1);
    clear_counts();
    @(posedge clk); #1;
    cfg_num_nij = 8'd36; cfg_num_kij = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int t = 0; t < 2000; t++) begin
      if (n_ps >= 5) begin got = 1; break; end
      @(posedge clk); #1;
    end
    check("reached_drain", 64'(got), 64'd1);
    mon_en = 0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_drain_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    mon_en = 1;

    // Recovery after reset
    run_job(2, 1, 0, 0, 0);
    check("recover_ps_count", 64'(n_ps), 64'd2);
    check("recover_last_ps", 64'(last_ps_addr), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
